// File: rtl/spi_slave_if.sv
// SPI slave bus bundle: serial pins plus the word-side handshake.
// Build with SPI_SLAVE_MISO_OE_EN to add miso_oe for an external tristate driver.
interface spi_slave_if #(
    parameter int WIDTH = 8
);
    logic             sclk;
    logic             ss_n;
    logic             mosi;
    logic             miso;
    logic [WIDTH-1:0] tx_data;
    logic             tx_taken;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;
`ifdef SPI_SLAVE_MISO_OE_EN
    logic             miso_oe;

    modport slave (
        input  sclk, ss_n, mosi, tx_data,
        output miso, miso_oe, tx_taken, rx_data, rx_valid, busy
    );
    modport master (
        output sclk, ss_n, mosi, tx_data,
        input  miso, miso_oe, tx_taken, rx_data, rx_valid, busy
    );
`else
    modport slave (
        input  sclk, ss_n, mosi, tx_data,
        output miso, tx_taken, rx_data, rx_valid, busy
    );
    modport master (
        output sclk, ss_n, mosi, tx_data,
        input  miso, tx_taken, rx_data, rx_valid, busy
    );
`endif
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled by the system clock through 2-flop synchronizers.
// Optional feature macro: SPI_SLAVE_MISO_OE_EN (adds miso_oe, high in LOAD/SHIFT).
module spi_slave #(
    parameter int WIDTH = 8
) (
    input logic       clock,
    input logic       reset,
    spi_slave_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [2:0]       sclk_s, ss_s, primed;
    logic [1:0]       mosi_s;
    logic [WIDTH-1:0] tx_sh, rx_sh, rx_q;
    logic [CW-1:0]    cnt;
    logic             done, miso_q, rx_valid_q;
    logic             sclk_rise, sclk_fall, ss_fall, ss_rise, word_end, reload;
    logic             busy, tx_taken;

    // Stage 0 samples the pin, stage 1 is the synchronized value, stage 2 the delayed copy.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_s <= '0;
            ss_s   <= '1;
            mosi_s <= '0;
            primed <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], bus.sclk};
            ss_s   <= {ss_s[1:0], bus.ss_n};
            mosi_s <= {mosi_s[0], bus.mosi};
            primed <= {primed[1:0], 1'b1};
        end
    end

    // primed keeps the reset-forced ss_n high from looking like a falling edge after release.
    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign ss_fall   = ~ss_s[1] & ss_s[2] & primed[2];
    assign ss_rise   = ss_s[1] & ~ss_s[2];
    assign word_end  = (cnt == CW'(WIDTH));
    assign reload    = (state == SHIFT) & sclk_fall & (cnt == '0) & done & ~ss_rise;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = LOAD;
            LOAD:    state_nxt = ss_rise ? IDLE : SHIFT;
            SHIFT:   if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        tx_taken = (state == LOAD) | reload;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_sh      <= '0;
            rx_sh      <= '0;
            rx_q       <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            miso_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    miso_q <= 1'b0;
                    cnt    <= '0;
                end
                LOAD: begin
                    tx_sh  <= bus.tx_data;
                    miso_q <= bus.tx_data[WIDTH-1];
                    cnt    <= '0;
                    done   <= 1'b0;
                end
                SHIFT: begin
                    if (sclk_rise && !word_end) begin
                        rx_sh <= {rx_sh[WIDTH-2:0], mosi_s[1]};
                        cnt   <= cnt + CW'(1);
                    end else if (sclk_fall) begin
                        if (cnt != '0) begin
                            tx_sh  <= tx_sh << 1;
                            miso_q <= tx_sh[WIDTH-2];
                        end else if (reload) begin
                            tx_sh  <= bus.tx_data;
                            miso_q <= bus.tx_data[WIDTH-1];
                            done   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
            // Delivery also runs from IDLE so a word completing as ss_n rises is not lost.
            if (word_end) begin
                rx_q       <= rx_sh;
                rx_valid_q <= 1'b1;
                cnt        <= '0;
                done       <= 1'b1;
            end
        end
    end

    assign bus.rx_data  = rx_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_taken = tx_taken;
    assign bus.busy     = busy;
`ifdef SPI_SLAVE_MISO_OE_EN
    assign bus.miso_oe  = busy;
    assign bus.miso     = miso_q;
`else
    assign bus.miso     = miso_q & busy;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: single word, back-to-back words, abort, mid-word reset, deselected sclk.
module tb_spi_slave;
    logic clock = 1'b0;
    logic reset;
    int   ncmp = 0;
    int   nerr = 0;
    int   rxv_n = 0;
    int   txt_n = 0;
    int   rx0, tx0;

    spi_slave_if #(.WIDTH(8)) bus ();

    spi_slave #(.WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.rx_valid) rxv_n++;
        if (bus.tx_taken) txt_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_oe(input string tag);
`ifdef SPI_SLAVE_MISO_OE_EN
        check(tag, {31'd0, bus.miso_oe}, {31'd0, bus.busy});
`endif
    endtask

    task automatic start_frame(input logic [7:0] tx);
        bus.tx_data = tx;
        bus.ss_n    = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    // Sends nbits of mo; checks miso against exp before each rise and rx_valid at its fixed latency.
    task automatic spi_word(input logic [7:0] mo, input logic [7:0] exp, input int nbits, input bit hold);
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = mo[7-i];
            repeat (4) @(negedge clock);
            check($sformatf("miso_bit%0d", i), {31'd0, bus.miso}, {31'd0, exp[7-i]});
            check_oe("miso_oe_shift");
            bus.sclk = 1'b1;
            repeat (4) @(negedge clock);
            if (i == 7) begin
                check("rx_valid_latency", {31'd0, bus.rx_valid}, 32'd1);
                check("rx_data_word", {24'd0, bus.rx_data}, {24'd0, mo});
            end
            if (!(hold && i == nbits - 1)) bus.sclk = 1'b0;
        end
    endtask

    task automatic end_frame();
        bus.sclk = 1'b0;
        bus.ss_n = 1'b1;
        repeat (6) @(negedge clock);
        check("busy_after_frame", {31'd0, bus.busy}, 32'd0);
        check_oe("miso_oe_idle");
    endtask

    initial begin
        reset       = 1'b1;
        bus.sclk    = 1'b0;
        bus.ss_n    = 1'b1;
        bus.mosi    = 1'b0;
        bus.tx_data = '0;
        repeat (3) @(negedge clock);
        check("rst_miso", {31'd0, bus.miso}, 32'd0);
        check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("rst_tx_taken", {31'd0, bus.tx_taken}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_oe("rst_miso_oe");
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Single word: slave sends 0xA5, master sends 0x3C.
        rx0 = rxv_n; tx0 = txt_n;
        start_frame(8'hA5);
        spi_word(8'h3C, 8'hA5, 8, 1'b1);
        end_frame();
        check("single_rx_data", {24'd0, bus.rx_data}, 32'h3C);
        check("single_rx_cnt", rxv_n - rx0, 32'd1);
        check("single_tx_cnt", txt_n - tx0, 32'd1);

        // Back-to-back words without deselect.
        rx0 = rxv_n; tx0 = txt_n;
        start_frame(8'h11);
        spi_word(8'h81, 8'h11, 8, 1'b0);
        bus.tx_data = 8'h22;
        spi_word(8'h7E, 8'h22, 8, 1'b1);
        end_frame();
        check("b2b_rx_data", {24'd0, bus.rx_data}, 32'h7E);
        check("b2b_rx_cnt", rxv_n - rx0, 32'd2);
        check("b2b_tx_cnt", txt_n - tx0, 32'd2);

        // Abort after 5 rising edges.
        rx0 = rxv_n; tx0 = txt_n;
        start_frame(8'h5A);
        spi_word(8'h99, 8'h5A, 5, 1'b0);
        bus.ss_n = 1'b1;
        repeat (3) @(negedge clock);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_oe("abort_miso_oe");
        repeat (6) @(negedge clock);
        check("abort_rx_data", {24'd0, bus.rx_data}, 32'h7E);
        check("abort_rx_cnt", rxv_n - rx0, 32'd0);
        check("abort_tx_cnt", txt_n - tx0, 32'd1);

        // Reset after 4 bits, ss_n held low through release.
        rx0 = rxv_n; tx0 = txt_n;
        start_frame(8'h00);
        spi_word(8'hF0, 8'h00, 4, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("midrst_no_restart", {31'd0, bus.busy}, 32'd0);
        check("midrst_tx_cnt", txt_n - tx0, 32'd1);
        bus.ss_n = 1'b1;
        repeat (6) @(negedge clock);
        start_frame(8'hC3);
        spi_word(8'hF0, 8'hC3, 8, 1'b1);
        end_frame();
        check("midrst_rx_data_new", {24'd0, bus.rx_data}, 32'hF0);
        check("midrst_rx_cnt", rxv_n - rx0, 32'd1);
        check("midrst_tx_cnt2", txt_n - tx0, 32'd2);

        // sclk toggling while deselected.
        rx0 = rxv_n; tx0 = txt_n;
        for (int i = 0; i < 8; i++) begin
            bus.mosi = i[0];
            bus.sclk = 1'b1;
            repeat (4) @(negedge clock);
            bus.sclk = 1'b0;
            repeat (4) @(negedge clock);
            check("desel_busy", {31'd0, bus.busy}, 32'd0);
            check("desel_miso", {31'd0, bus.miso}, 32'd0);
        end
        check("desel_rx_cnt", rxv_n - rx0, 32'd0);
        check("desel_tx_cnt", txt_n - tx0, 32'd0);
        check("desel_rx_data", {24'd0, bus.rx_data}, 32'hF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
